adder_result_stage: RTL and testbench
=====================================

// Module: adder_result_stage
// PURPOSE
//   Registered output stage directly downstream of the 32-bit ripple-carry adder.
//   Captures sum/cout/overflow, applies optional signed saturation and derives NZCV flags.
//   Buffers results in a 2-entry skid buffer behind a valid/ready handshake.
//   Keeps a sticky overflow flag and a saturating overflow-event counter for the sequencer.
// PARAMETERS
//   WIDTH     32  datapath width; must match the adder width
//   SATURATE  1   1: clamp signed overflow to max/min; 0: pass wrapped sum unchanged
//   CNT_W     16  width of the overflow event counter
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      adder result valid this cycle
//   in_ready     out  1      stage can accept; registered, depends only on buffer state
//   in_sum       in   WIDTH  adder sum
//   in_cout      in   1      adder carry out
//   in_overflow  in   1      adder signed overflow
//   out_valid    out  1      out_result/out_flags valid
//   out_ready    in   1      consumer accepts this cycle
//   out_result   out  WIDTH  final (possibly saturated) result
//   out_flags    out  4      {N,Z,C,V}
//   sticky_ovf   out  1      set by any accepted overflow; held until cleared
//   sticky_clr   in   1      synchronous clear of sticky_ovf and ovf_count
//   ovf_count    out  CNT_W  count of accepted overflow results; saturates at all-ones
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - out_valid=0, in_ready=1, out_result=0, out_flags=0, sticky_ovf=0, ovf_count=0.
//   - Reset mid-operation discards both buffer entries; nothing is replayed.
//   Transfers:
//   - Accept when in_valid&in_ready; emit when out_valid&out_ready.
//   - Latency 1: a result accepted in cycle N is on the outputs in N+1 when the buffer was empty.
//   Result/flag formation (at accept time):
//   - SATURATE=1 & in_overflow & in_sum[MSB]=1 -> result = 0x7FFF_FFFF (positive overflow).
//   - SATURATE=1 & in_overflow & in_sum[MSB]=0 -> result = 0x8000_0000.
//   - Otherwise result = in_sum.
//   - N = result[MSB]; Z = (result==0); C = in_cout; V = in_overflow (raw, not cleared by saturation).
//   State machine (main register M, skid register S):
//   - EMPTY: out_valid=0, in_ready=1; accept -> ONE (load M).
//   - ONE: out_valid=1, in_ready=1.
//       accept & emit -> ONE (M reloaded).
//       accept & !emit -> FULL (load S).
//       emit & !accept -> EMPTY.
//   - FULL: out_valid=1, in_ready=0; emit -> ONE (M<=S). Input is ignored even if in_valid=1.
//   - Outputs stay stable while out_valid & !out_ready; order is strictly FIFO.
//   Sticky/counter:
//   - On accept with in_overflow: sticky_ovf<=1 and ovf_count+1, held at 2^CNT_W-1 once reached.
//   - sticky_clr with an overflow accept in the same cycle: sticky_ovf=1, ovf_count=1 (set wins).
//   - sticky_clr alone: both cleared next cycle. Counter never wraps.
// TESTING
//   1. Reset, then in_sum=0x0000_0005, cout=0, ovf=0, out_ready=1
//      -> next cycle out_result=5, flags=0000, in_ready=1.
//   2. SATURATE=1: in_sum=0x8000_0000, ovf=1, cout=0
//      -> out_result=0x7FFF_FFFF, flags=0001, sticky_ovf=1, ovf_count=1.
//   3. out_ready=0, drive 3 back-to-back valids A,B,C
//      -> A in M, B in S, in_ready=0, C held.
//      Raise out_ready -> A, B, C emitted in order.
//   4. in_sum=0, cout=1, ovf=0 -> flags=0110 (Z,C). SATURATE=0 with ovf=1 -> raw sum passed, V=1.
//   5. Preload ovf_count=0xFFFF via overflow stream, one more overflow -> stays 0xFFFF.
//      sticky_clr together with an overflow accept -> count=1, sticky=1.
//   6. Assert rst_n=0 while FULL
//      -> out_valid=0, in_ready=1 immediately; no stale data after release.

Source files
------------

// File: rtl/adder_result_stage.sv
// Registered result stage behind the ripple-carry adder: optional signed saturation, NZCV flags,
// a 2-entry skid buffer on a valid/ready handshake, and sticky overflow tracking.
module adder_result_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             sticky_ovf,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q;
  logic             out_valid_q, in_ready_q;
  logic [WIDTH-1:0] m_result_q, s_result_q;
  logic [3:0]       m_flags_q, s_flags_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept, emit;
  logic [WIDTH-1:0] new_result;
  logic [3:0]       new_flags;

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  // A wrapped negative sum means the true result overflowed positive, and vice versa.
  always_comb begin
    new_result = in_sum;
    if (SATURATE && in_overflow) begin
      new_result = in_sum[WIDTH-1] ? MaxPos : MinNeg;
    end
    new_flags = {new_result[WIDTH-1], (new_result == '0), in_cout, in_overflow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      m_result_q  <= '0;
      m_flags_q   <= '0;
      s_result_q  <= '0;
      s_flags_q   <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            m_result_q  <= new_result;
            m_flags_q   <= new_flags;
            out_valid_q <= 1'b1;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && emit) begin
            m_result_q <= new_result;
            m_flags_q  <= new_flags;
          end else if (accept) begin
            s_result_q <= new_result;
            s_flags_q  <= new_flags;
            in_ready_q <= 1'b0;
            state_q    <= StFull;
          end else if (emit) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          if (emit) begin
            m_result_q <= s_result_q;
            m_flags_q  <= s_flags_q;
            in_ready_q <= 1'b1;
            state_q    <= StOne;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // An overflow accepted alongside a clear restarts the count at one rather than zero.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (accept && in_overflow) begin
      sticky_d = 1'b1;
      if (sticky_clr) begin
        count_d = CntOne;
      end else if (count_q != '1) begin
        count_d = count_q + CntOne;
      end
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = m_result_q;
  assign out_flags  = m_flags_q;
  assign sticky_ovf = sticky_q;
  assign ovf_count  = count_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: a saturating and a wrapping instance driven by the same stimulus,
// each checked every cycle against a queue-based model, plus directed literal checks.
module tb_adder_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_cout, in_overflow, out_ready, sticky_clr;
  logic [31:0] in_sum;

  logic        in_ready0, out_valid0, sticky0;
  logic [31:0] result0;
  logic [3:0]  flags0;
  logic [15:0] count0;
  logic        in_ready1, out_valid1, sticky1;
  logic [31:0] result1;
  logic [3:0]  flags1;
  logic [3:0]  count1;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  adder_result_stage #(.WIDTH(32), .SATURATE(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_sum(in_sum),
    .in_cout(in_cout), .in_overflow(in_overflow), .out_valid(out_valid0), .out_ready(out_ready),
    .out_result(result0), .out_flags(flags0), .sticky_ovf(sticky0), .sticky_clr(sticky_clr),
    .ovf_count(count0)
  );

  adder_result_stage #(.WIDTH(32), .SATURATE(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_sum(in_sum),
    .in_cout(in_cout), .in_overflow(in_overflow), .out_valid(out_valid1), .out_ready(out_ready),
    .out_result(result1), .out_flags(flags1), .sticky_ovf(sticky1), .sticky_clr(sticky_clr),
    .ovf_count(count1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model entry packs {result[31:0], N, Z, C, V}.
  function automatic logic [35:0] form(input logic [31:0] s, input logic c, input logic v,
                                       input bit sat);
    logic [31:0] r;
    r = s;
    if (sat && v) r = s[31] ? 32'h7fff_ffff : 32'h8000_0000;
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  logic [35:0] q0[$], q1[$];
  bit          stk0, stk1;
  int          cnt0, cnt1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q1.delete();
      stk0 = 1'b0; stk1 = 1'b0; cnt0 = 0; cnt1 = 0;
    end else begin
      bit acc0, acc1;
      acc0 = in_valid && (q0.size() < 2);
      acc1 = in_valid && (q1.size() < 2);
      if (out_ready && q0.size() > 0) void'(q0.pop_front());
      if (out_ready && q1.size() > 0) void'(q1.pop_front());
      if (acc0) q0.push_back(form(in_sum, in_cout, in_overflow, 1'b1));
      if (acc1) q1.push_back(form(in_sum, in_cout, in_overflow, 1'b0));
      if (acc0 && in_overflow) begin
        stk0 = 1'b1;
        cnt0 = sticky_clr ? 1 : ((cnt0 + 1 > 65535) ? 65535 : cnt0 + 1);
      end else if (sticky_clr) begin
        stk0 = 1'b0; cnt0 = 0;
      end
      if (acc1 && in_overflow) begin
        stk1 = 1'b1;
        cnt1 = sticky_clr ? 1 : ((cnt1 + 1 > 15) ? 15 : cnt1 + 1);
      end else if (sticky_clr) begin
        stk1 = 1'b0; cnt1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [35:0] e;
      chk("m0 out_valid", 64'(out_valid0), 64'(q0.size() > 0));
      chk("m0 in_ready", 64'(in_ready0), 64'(q0.size() < 2));
      if (q0.size() > 0) begin
        e = q0[0];
        chk("m0 result", 64'(result0), 64'(e[35:4]));
        chk("m0 flags", 64'(flags0), 64'(e[3:0]));
      end
      chk("m0 sticky", 64'(sticky0), 64'(stk0));
      chk("m0 count", 64'(count0), 64'(cnt0));
      chk("m1 out_valid", 64'(out_valid1), 64'(q1.size() > 0));
      chk("m1 in_ready", 64'(in_ready1), 64'(q1.size() < 2));
      if (q1.size() > 0) begin
        e = q1[0];
        chk("m1 result", 64'(result1), 64'(e[35:4]));
        chk("m1 flags", 64'(flags1), 64'(e[3:0]));
      end
      chk("m1 sticky", 64'(sticky1), 64'(stk1));
      chk("m1 count", 64'(count1), 64'(cnt1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] s, input logic c, input logic o,
                       input logic rdy, input logic clr);
    in_valid = v; in_sum = s; in_cout = c; in_overflow = o; out_ready = rdy; sticky_clr = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("reset out_valid", 64'(out_valid0), 64'd0);
    chk("reset in_ready", 64'(in_ready0), 64'd1);
    chk("reset result", 64'(result0), 64'd0);
    chk("reset flags", 64'(flags0), 64'd0);
    chk("reset sticky", 64'(sticky0), 64'd0);
    chk("reset count", 64'(count0), 64'd0);
    rst_n = 1'b1;
    check_en = 1'b1;
    cyc();

    drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("t1 result", 64'(result0), 64'd5);
    chk("t1 flags", 64'(flags0), 64'h0);
    chk("t1 in_ready", 64'(in_ready0), 64'd1);

    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("t2 sat result", 64'(result0), 64'h7fff_ffff);
    chk("t2 sat flags", 64'(flags0), 64'h1);
    chk("t2 sticky", 64'(sticky0), 64'd1);
    chk("t2 count", 64'(count0), 64'd1);
    chk("t2 wrap result", 64'(result1), 64'h8000_0000);
    chk("t2 wrap flags", 64'(flags1), 64'h9);

    drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("t4 zero flags", 64'(flags0), 64'h6);
    drive(1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("t4 sat neg", 64'(result0), 64'h8000_0000);
    chk("t4 raw sum", 64'(result1), 64'h0000_1234);
    chk("t4 raw flags", 64'(flags1), 64'h3);

    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    in_sum = 32'hB;
    cyc();
    in_sum = 32'hC;
    cyc();
    chk("t3 full in_ready", 64'(in_ready0), 64'd0);
    chk("t3 head A", 64'(result0), 64'hA);
    out_ready = 1'b1;
    cyc();
    chk("t3 then B", 64'(result0), 64'hB);
    cyc();
    chk("t3 then C", 64'(result0), 64'hC);
    in_valid = 1'b0;
    cyc();
    chk("t3 drained", 64'(out_valid0), 64'd0);

    drive(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) cyc();
    chk("t5 count sat", 64'(count1), 64'hF);
    sticky_clr = 1'b1;
    cyc();
    chk("t5 clr+ovf count", 64'(count1), 64'd1);
    chk("t5 clr+ovf sticky", 64'(sticky1), 64'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("t5 clr count", 64'(count0), 64'd0);
    chk("t5 clr sticky", 64'(sticky0), 64'd0);

    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc();
    chk("t6 full", 64'(in_ready0), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t6 rst out_valid", 64'(out_valid0), 64'd0);
    chk("t6 rst in_ready", 64'(in_ready0), 64'd1);
    cyc();
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc();
    chk("t6 no replay", 64'(out_valid0), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] s;
      case ($urandom_range(0, 3))
        0: s = 32'd0;
        1: s = 32'h8000_0000;
        2: s = 32'h7fff_ffff;
        default: s = $urandom;
      endcase
      drive(($urandom_range(0, 9) < 7), s, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      cyc();
    end

    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
